gtech_parity_pipe: RTL

- Parametrised, pipelined multi-lane XOR/XNOR reduction block for the GTECH generic library.
- Each of LANES input lanes (WIDTH bits each) is reduced to one parity bit through a registered radix-3 tree of XOR3 cells.
- Supports a per-beat XNOR mode and parity accumulation across multi-beat frames.
- Sits between datapath producers and ECC/parity checkers; uses valid/ready flow control.

---
 rtl/gtech_pkg.sv | 48 ++++
 rtl/gtech_xor3_stage.sv | 47 ++++
 rtl/gtech_parity_pipe.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/gtech_pkg.sv
// Shared helpers for the GTECH parity pipeline: radix-3 tree sizing and the
// per-beat control sideband carried alongside the tree data.
package gtech_pkg;

    localparam int unsigned MAX_WIDTH = 243;

    // Control bits sampled with each beat and carried through the tree
    typedef struct packed {
        logic mode;
        logic acc_en;
        logic last;
    } sb_t;

    // Number of radix-3 reduction levels needed to bring n bits down to one
    function automatic int unsigned clog3(input int unsigned n);
        int unsigned w;
        int unsigned l;
        w = n;
        l = 0;
        while (w > 1) begin
            w = (w + 2) / 3;
            l = l + 1;
        end
        return l;
    endfunction

    // Per-lane width after lvl levels of reduction: ceil(n / 3^lvl)
    function automatic int unsigned level_width(input int unsigned n, input int unsigned lvl);
        int unsigned w;
        w = n;
        for (int unsigned i = 0; i < lvl; i++) begin
            w = (w + 2) / 3;
        end
        return w;
    endfunction

    // Bit offset of level lvl inside the flattened all-levels tree bus
    function automatic int unsigned tree_offset(input int unsigned n, input int unsigned lanes,
                                                input int unsigned lvl);
        int unsigned off;
        off = 0;
        for (int unsigned i = 0; i < lvl; i++) begin
            off = off + lanes * level_width(n, i);
        end
        return off;
    endfunction

endpackage

// File: rtl/gtech_xor3_stage.sv
// One registered level of the radix-3 XOR tree. Each lane is zero-padded at
// the MSB end to a multiple of three, reduced with XOR3 per group, and
// registered together with its valid and sideband bits.
module gtech_xor3_stage #(
    parameter int unsigned IN_W  = 3,
    parameter int unsigned LANES = 1,
    parameter int unsigned SB_W  = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic                               in_valid,
    input  logic [LANES*IN_W-1:0]              in_data,
    input  logic [SB_W-1:0]                    in_sb,
    output logic                               out_valid,
    output logic [LANES*((IN_W+2)/3)-1:0]      out_data,
    output logic [SB_W-1:0]                    out_sb
);

    localparam int unsigned OUT_W = (IN_W + 2) / 3;
    localparam int unsigned PAD_W = 3 * OUT_W;

    logic [LANES*OUT_W-1:0] red;

    // XOR3 reduction per group of three bits, per lane
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [PAD_W-1:0] lane_pad;
        assign lane_pad = PAD_W'(in_data[k*IN_W +: IN_W]);
        for (genvar g = 0; g < OUT_W; g++) begin : g_grp
            assign red[k*OUT_W + g] = ^lane_pad[3*g +: 3];
        end
    end

    // Level register; frozen with the rest of the pipe when en is low
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sb    <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= red;
            out_sb    <= in_sb;
        end
    end

endmodule

// File: rtl/gtech_parity_pipe.sv
// Pipelined multi-lane parity reduction with per-beat XNOR mode and running
// frame parity. Optional macro GTECH_PARITY_PIPE_CHK_EN adds an expected-
// parity input (IN_EXP) and per-lane / sticky error outputs (ERR, ERR_STICKY).
module gtech_parity_pipe
    import gtech_pkg::*;
#(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned LANES = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [LANES*WIDTH-1:0] IN_DATA,
    input  logic                   IN_LAST,
    input  logic                   MODE,
    input  logic                   ACC_EN,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [LANES-1:0]       OUT_Z,
    output logic                   OUT_LAST
`ifdef GTECH_PARITY_PIPE_CHK_EN
    ,
    input  logic [LANES-1:0]       IN_EXP,
    output logic [LANES-1:0]       ERR,
    output logic                   ERR_STICKY
`endif
);

    localparam int unsigned LEVELS = clog3(WIDTH);
    localparam int unsigned CTL_W  = $bits(sb_t);
`ifdef GTECH_PARITY_PIPE_CHK_EN
    localparam int unsigned SB_W   = CTL_W + LANES;
`else
    localparam int unsigned SB_W   = CTL_W;
`endif
    localparam int unsigned TREE_W = tree_offset(WIDTH, LANES, LEVELS + 1);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("gtech_parity_pipe: WIDTH outside 2..243");
    end

    logic              advance;
    logic [TREE_W-1:0] tree_bus;
    logic              lvl_valid [LEVELS+1];
    logic [SB_W-1:0]   lvl_sb    [LEVELS+1];
    sb_t               beat_ctl;
    sb_t               tree_ctl;
    logic [LANES-1:0]  tree_z;
    logic [LANES-1:0]  acc_q;
    logic [LANES-1:0]  raw_c;
    logic [LANES-1:0]  acc_d_c;
    logic [LANES-1:0]  z_d_c;

    // Whole pipe moves together unless a held result is blocking the output
    assign advance  = ~OUT_VALID | OUT_READY;
    assign IN_READY = advance;

    assign beat_ctl      = '{mode: MODE, acc_en: ACC_EN, last: IN_LAST};
    assign tree_bus[LANES*WIDTH-1:0] = IN_DATA;
    assign lvl_valid[0]  = IN_VALID;
`ifdef GTECH_PARITY_PIPE_CHK_EN
    assign lvl_sb[0]     = {IN_EXP, beat_ctl};
`else
    assign lvl_sb[0]     = beat_ctl;
`endif

    // Chain of registered tree levels; each level's slice of tree_bus feeds the next
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int unsigned IW   = level_width(WIDTH, l);
        localparam int unsigned OW   = level_width(WIDTH, l + 1);
        localparam int unsigned IOFF = tree_offset(WIDTH, LANES, l);
        localparam int unsigned OOFF = tree_offset(WIDTH, LANES, l + 1);

        gtech_xor3_stage #(
            .IN_W  (IW),
            .LANES (LANES),
            .SB_W  (SB_W)
        ) u_stage (
            .clk       (CLK),
            .rst       (RST),
            .en        (advance),
            .in_valid  (lvl_valid[l]),
            .in_data   (tree_bus[IOFF +: LANES*IW]),
            .in_sb     (lvl_sb[l]),
            .out_valid (lvl_valid[l+1]),
            .out_data  (tree_bus[OOFF +: LANES*OW]),
            .out_sb    (lvl_sb[l+1])
        );
    end

    assign tree_z   = tree_bus[TREE_W-1 -: LANES];
    assign tree_ctl = lvl_sb[LEVELS][CTL_W-1:0];

    // Running true parity; inversion happens only on the way out
    always_comb begin
        raw_c   = tree_z;
        acc_d_c = '0;
        if (tree_ctl.acc_en) begin
            raw_c = tree_z ^ acc_q;
            if (!tree_ctl.last) begin
                acc_d_c = raw_c;
            end
        end
        z_d_c = raw_c ^ {LANES{tree_ctl.mode}};
    end

    // Output stage and accumulator, loaded only when a beat leaves the tree
    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            OUT_Z     <= '0;
            OUT_LAST  <= 1'b0;
            acc_q     <= '0;
        end else if (advance) begin
            OUT_VALID <= lvl_valid[LEVELS];
            if (lvl_valid[LEVELS]) begin
                OUT_Z    <= z_d_c;
                OUT_LAST <= tree_ctl.last;
                acc_q    <= acc_d_c;
            end
        end
    end

`ifdef GTECH_PARITY_PIPE_CHK_EN
    logic [LANES-1:0] tree_exp;
    logic [LANES-1:0] err_d_c;

    assign tree_exp = lvl_sb[LEVELS][SB_W-1 -: LANES];
    assign err_d_c  = z_d_c ^ tree_exp;

    // Per-beat mismatch flags and a sticky summary cleared only by reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            ERR        <= '0;
            ERR_STICKY <= 1'b0;
        end else if (advance) begin
            if (lvl_valid[LEVELS]) begin
                ERR        <= err_d_c;
                ERR_STICKY <= ERR_STICKY | (|err_d_c);
            end else begin
                ERR        <= '0;
            end
        end
    end
`endif

endmodule
